// File: rtl/mips_pkg.sv
// Shared EX-stage definitions for the sequential multiplier.
// FSM state encoding and default operand width.
package mips_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// One shift-add multiply iteration (combinational).
// Ports: acc/mb/ma in, next acc/mb out.
module mul_shift_add
  import mips_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mb,
  input  logic [WIDTH-1:0] ma,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] mb_n
);

  logic [WIDTH:0] sum;

  // The carry of the add is shifted back into
  // the top of acc, so no product bit is lost.
  always_comb begin
    sum = {1'b0, acc};
    if (mb[0]) begin
      sum = {1'b0, acc} + {1'b0, ma};
    end
    acc_n = sum[WIDTH:1];
    mb_n  = {sum[0], mb[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_seq_unit.sv
// Multi-cycle MULT/MULTU unit writing HiLo; stalls MFHI/MFLO.
// Ports: start/signed/a/b/abort/hilo_rd in; busy/stall/done/hi/lo out.
module mult_seq_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             hilo_rd_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(WIDTH - 1);

  mul_state_e state;
  mul_state_e state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] acc;
  logic             neg;

  logic [WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]   mb_n;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc   (acc),
    .mb    (mb),
    .ma    (ma),
    .acc_n (acc_n),
    .mb_n  (mb_n)
  );

  // The most negative operand negates to itself,
  // which read as unsigned is the right magnitude.
  always_comb begin
    a_mag = a_i;
    b_mag = b_i;
    if (signed_i && a_i[WIDTH-1]) begin
      a_mag = -a_i;
    end
    if (signed_i && b_i[WIDTH-1]) begin
      b_mag = -b_i;
    end
  end

  // Product includes the iteration of the
  // current (last) edge.
  always_comb begin
    last     = (cnt == CNT_LAST);
    prod_mag = {acc_n, mb_n};
    prod     = prod_mag;
    if (neg) begin
      prod = -prod_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MUL_IDLE: begin
        if (start_i) begin
          state_n = MUL_CALC;
        end
      end
      MUL_CALC: begin
        if (abort_i) begin
          state_n = MUL_IDLE;
        end else if (last) begin
          state_n = MUL_DONE;
        end
      end
      MUL_DONE: begin
        state_n = MUL_IDLE;
      end
      default: begin
        state_n = MUL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      ma   <= '0;
      mb   <= '0;
      acc  <= '0;
      neg  <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else if (state == MUL_IDLE) begin
      if (start_i) begin
        ma  <= a_mag;
        mb  <= b_mag;
        acc <= '0;
        cnt <= '0;
        neg <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      end
    end else if (state == MUL_CALC && !abort_i) begin
      acc <= acc_n;
      mb  <= mb_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        hi_o <= prod[2*WIDTH-1:WIDTH];
        lo_o <= prod[WIDTH-1:0];
      end
    end
  end

  assign busy_o  = (state != MUL_IDLE);
  assign done_o  = (state == MUL_DONE);
  assign stall_o = busy_o & hilo_rd_i;

endmodule
